// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and helpers for the instruction-memory
// responder and anything that consumes its fetch responses.
package imem_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) for downstream fetch consumers.
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  // Legal parameter ranges for the responder timing knobs.
  localparam int unsigned IMEM_GNT_WAIT_MAX   = 7;
  localparam int unsigned IMEM_RVALID_LAT_MIN = 1;
  localparam int unsigned IMEM_RVALID_LAT_MAX = 4;

  // One slot of the response pipe.
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } imem_resp_t;

  // Integrity field: even parity in bit 0, upper bits reserved as zero.
  function automatic logic [6:0] imem_intg(input logic [31:0] data);
    return {6'b000000, ^data};
  endfunction

endpackage

// File: rtl/imem_obi_slave_if.sv
// imem_obi_slave_if: fetch request/response channel between a core's
// instruction port (master) and the instruction memory (slave).
interface imem_obi_slave_if;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic [6:0]  instr_rdata_intg;
  logic        instr_err;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata,
    input  instr_rdata_intg,
    input  instr_err
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata,
    output instr_rdata_intg,
    output instr_err
  );

endinterface

// File: rtl/imem_resp_pipe.sv
// imem_resp_pipe: fixed-depth shift register carrying fetch responses from
// the grant cycle to the output. Shifts every cycle; no backpressure.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  imem_resp_t resp_i,
  output imem_resp_t resp_o
);

  imem_resp_t respStage_q [STAGES];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        respStage_q[i] <= '0;
      end
    end else begin
      respStage_q[0] <= resp_i;
      for (int i = 1; i < STAGES; i++) begin
        respStage_q[i] <= respStage_q[i-1];
      end
    end
  end

  assign resp_o = respStage_q[STAGES-1];

endmodule

// File: rtl/imem_obi_slave.sv
// imem_obi_slave: instruction-memory responder with configurable grant wait
// states and response latency, backed by a preloadable word array.
module imem_obi_slave
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned RVALID_LAT  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  imem_obi_slave_if.slave                instr_bus,
  input  logic                           load_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                    load_wdata_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [2:0]  waitCnt_q, waitCnt_d;
  logic        grant;
  logic [31:0] wordIndex;
  logic        addrErr;
  logic [31:0] readWord;
  logic        respValid;
  imem_resp_t  respIn, respOut;

  // Not reset: contents are whatever was last preloaded.
  logic [31:0] memArray [DEPTH_WORDS];

  // Grant once the request has waited the configured number of cycles.
  // Reset masks the grant so nothing is accepted during reset.
  assign grant = instr_bus.instr_req && !rst_i && (waitCnt_q == 3'(GNT_WAIT));
  assign instr_bus.instr_gnt = grant;

  // Wait counter: counts ungranted request cycles, restarts on grant or drop.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!instr_bus.instr_req || grant) begin
      waitCnt_d = 3'd0;
    end else begin
      waitCnt_d = waitCnt_q + 3'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waitCnt_q <= 3'd0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  // Address decode: word index relative to the base; misaligned or
  // out-of-range fetches become error responses.
  assign wordIndex = (instr_bus.instr_addr - BASE_ADDR) >> 2;
  assign addrErr   = (instr_bus.instr_addr[1:0] != 2'b00) ||
                     (wordIndex >= 32'(DEPTH_WORDS));
  assign readWord  = memArray[wordIndex[IDX_W-1:0]];

  // Preload port. The fetch read above is combinational on the old contents,
  // so a same-cycle grant to the written word captures pre-write data.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      memArray[load_addr_i] <= load_wdata_i;
    end
  end

  // Build the response entering the pipe in the grant cycle.
  always_comb begin
    respIn = '0;
    if (grant) begin
      respIn.valid = 1'b1;
      if (addrErr) begin
        respIn.err = 1'b1;
      end else begin
        respIn.data = readWord;
      end
    end
  end

  imem_resp_pipe #(
    .STAGES (RVALID_LAT)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .resp_i (respIn),
    .resp_o (respOut)
  );

  // Outputs are forced quiet while reset is held, so a response that was
  // about to emerge is dropped along with the rest of the pipe.
  assign respValid                  = respOut.valid && !rst_i;
  assign instr_bus.instr_rvalid     = respValid;
  assign instr_bus.instr_rdata      = respValid ? respOut.data : 32'h0;
  assign instr_bus.instr_err        = respValid && respOut.err;
  assign instr_bus.instr_rdata_intg = respValid ? imem_intg(respOut.data) : 7'h00;

endmodule

// File: tb/tb_imem_obi_slave.sv
// tb_imem_obi_slave: drives three differently configured responders with
// identical stimulus; a reference model predicts grants and queues expected
// responses, and a separate monitor checks every output cycle.
module tb_imem_obi_slave;
  import imem_pkg::*;

  localparam int NLANES = 3;
  localparam int GW0 = 0, RL0 = 1, DEP0 = 1024;
  localparam int GW1 = 3, RL1 = 2, DEP1 = 256;
  localparam int GW2 = 0, RL2 = 3, DEP2 = 512;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam logic [31:0] BASE2 = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] raw, wdata;
  logic [9:0]  laddr;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] refMem [NLANES][1024];
  int          held [NLANES];
  exp_t        expQ [NLANES][$];

  logic        gntW [NLANES];
  logic        rvW  [NLANES];
  logic [31:0] rdW  [NLANES];
  logic [6:0]  igW  [NLANES];
  logic        errW [NLANES];

  imem_obi_slave_if bus0 ();
  imem_obi_slave_if bus1 ();
  imem_obi_slave_if bus2 ();

  // Each lane sees the same offset from its own base address.
  assign bus0.instr_req  = req;
  assign bus1.instr_req  = req;
  assign bus2.instr_req  = req;
  assign bus0.instr_addr = raw + BASE0;
  assign bus1.instr_addr = raw + BASE1;
  assign bus2.instr_addr = raw + BASE2;

  assign gntW[0] = bus0.instr_gnt;        assign gntW[1] = bus1.instr_gnt;        assign gntW[2] = bus2.instr_gnt;
  assign rvW[0]  = bus0.instr_rvalid;     assign rvW[1]  = bus1.instr_rvalid;     assign rvW[2]  = bus2.instr_rvalid;
  assign rdW[0]  = bus0.instr_rdata;      assign rdW[1]  = bus1.instr_rdata;      assign rdW[2]  = bus2.instr_rdata;
  assign igW[0]  = bus0.instr_rdata_intg; assign igW[1]  = bus1.instr_rdata_intg; assign igW[2]  = bus2.instr_rdata_intg;
  assign errW[0] = bus0.instr_err;        assign errW[1] = bus1.instr_err;        assign errW[2] = bus2.instr_err;

  imem_obi_slave #(.DEPTH_WORDS(DEP0), .BASE_ADDR(BASE0), .GNT_WAIT(GW0), .RVALID_LAT(RL0)) dut0 (
    .clk_i(clk), .rst_i(rst), .instr_bus(bus0.slave),
    .load_we_i(we), .load_addr_i(laddr[9:0]), .load_wdata_i(wdata));

  imem_obi_slave #(.DEPTH_WORDS(DEP1), .BASE_ADDR(BASE1), .GNT_WAIT(GW1), .RVALID_LAT(RL1)) dut1 (
    .clk_i(clk), .rst_i(rst), .instr_bus(bus1.slave),
    .load_we_i(we), .load_addr_i(laddr[7:0]), .load_wdata_i(wdata));

  imem_obi_slave #(.DEPTH_WORDS(DEP2), .BASE_ADDR(BASE2), .GNT_WAIT(GW2), .RVALID_LAT(RL2)) dut2 (
    .clk_i(clk), .rst_i(rst), .instr_bus(bus2.slave),
    .load_we_i(we), .load_addr_i(laddr[8:0]), .load_wdata_i(wdata));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gwOf(input int k);
    return (k == 0) ? GW0 : (k == 1) ? GW1 : GW2;
  endfunction

  function automatic int rlOf(input int k);
    return (k == 0) ? RL0 : (k == 1) ? RL1 : RL2;
  endfunction

  function automatic int depOf(input int k);
    return (k == 0) ? DEP0 : (k == 1) ? DEP1 : DEP2;
  endfunction

  task automatic compare(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s lane%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; the model predicts the grant, queues the response
  // (using memory contents before any same-cycle load), then applies the load.
  task automatic applyStimulus(input logic rstV, input logic reqV, input logic [31:0] rawV,
                               input logic weV, input logic [9:0] laddrV, input logic [31:0] wdataV);
    logic expGnt;
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    rst = rstV; req = reqV; raw = rawV; we = weV; laddr = laddrV; wdata = wdataV;
    @(negedge clk);
    for (int k = 0; k < NLANES; k++) begin
      expGnt = 1'b0;
      if (rstV || !reqV) begin
        held[k] = 0;
      end else if (held[k] == gwOf(k)) begin
        expGnt  = 1'b1;
        held[k] = 0;
      end else begin
        held[k]++;
      end
      compare("gnt", k, {31'b0, gntW[k]}, {31'b0, expGnt});
      if (expGnt) begin
        idx    = int'(rawV >> 2);
        e.err  = (rawV[1:0] != 2'b00) || (idx >= depOf(k));
        e.data = e.err ? 32'h0 : refMem[k][idx];
        e.due  = cyc + rlOf(k);
        expQ[k].push_back(e);
      end
      if (weV) refMem[k][int'(laddrV) % depOf(k)] = wdataV;
    end
  endtask

  // Compare one lane's response outputs against the head of its queue.
  task automatic checkOutput(input int k);
    exp_t e;
    int   ones;
    if (rst) begin
      compare("rvalid_in_reset", k, {31'b0, rvW[k]}, 32'h0);
      compare("rdata_in_reset", k, rdW[k], 32'h0);
      compare("intg_in_reset", k, {25'b0, igW[k]}, 32'h0);
      compare("err_in_reset", k, {31'b0, errW[k]}, 32'h0);
      expQ[k].delete();
    end else if (expQ[k].size() > 0 && expQ[k][0].due <= cyc) begin
      e    = expQ[k].pop_front();
      ones = $countones(e.data);
      compare("rvalid", k, {31'b0, rvW[k]}, 32'h1);
      compare("rdata", k, rdW[k], e.data);
      compare("err", k, {31'b0, errW[k]}, {31'b0, e.err});
      compare("intg", k, {25'b0, igW[k]}, 32'(ones % 2));
    end else begin
      compare("rvalid_idle", k, {31'b0, rvW[k]}, 32'h0);
      compare("rdata_idle", k, rdW[k], 32'h0);
      compare("intg_idle", k, {25'b0, igW[k]}, 32'h0);
    end
  endtask

  // Monitor: independent of the stimulus process, checks every cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NLANES; k++) checkOutput(k);
  end

  initial begin
    logic        reqV, rstV, weV;
    logic [31:0] rawV;
    logic [31:0] prog [4];
    int          sel;
    prog[0] = 32'h0000_0013; prog[1] = 32'h0050_0093;
    prog[2] = 32'h00A0_0113; prog[3] = 32'h0020_81B3;
    rst = 1'b1; req = 1'b0; raw = 32'h0; we = 1'b0; laddr = 10'h0; wdata = 32'h0;
    for (int k = 0; k < NLANES; k++) held[k] = 0;

    // Reset with a pending request: no grant may appear.
    repeat (3) applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 10'h0, 32'h0);

    // Preload descending so the low words win in the smaller, aliasing lanes.
    for (int i = 1023; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 10'(i), (i < 4) ? prog[i] : $urandom());
    end

    // Back-to-back fetches of the first four words.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'(4 * i), 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Held request to word 1.
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Misaligned and out-of-range fetches.
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0000_1002, 1'b0, 10'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'(4 * DEP0), 1'b0, 10'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'(4 * DEP1), 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Load word 2 in the same cycle it is granted, then fetch it again.
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 10'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b1, 10'd2, 32'hDEAD_BEEF);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Request dropped part way through the wait, then reasserted.
    repeat (2) applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 10'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h4, 1'b0, 10'h0, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'hC, 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Three grants in flight, then a one-cycle reset drops them all.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'(4 * i), 1'b0, 10'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'hC, 1'b0, 10'h0, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Randomized traffic: bursty requests, mixed addresses, loads, resets.
    reqV = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) reqV = !reqV;
      rstV = ($urandom_range(0, 299) == 0);
      sel  = int'($urandom_range(0, 9));
      case (sel)
        0:       rawV = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        1:       rawV = 32'hFFFF_FFFC - (32'($urandom_range(0, 3)) << 2);
        2:       rawV = 32'($urandom_range(1020, 1030)) << 2;
        3:       rawV = 32'($urandom_range(250, 260)) << 2;
        4:       rawV = 32'($urandom_range(508, 516)) << 2;
        default: rawV = 32'($urandom_range(0, 63)) << 2;
      endcase
      weV = ($urandom_range(0, 2) == 0);
      applyStimulus(rstV, reqV, rawV, weV, 10'($urandom_range(0, 63)), $urandom());
    end

    // Drain and confirm every expected response was delivered.
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    for (int k = 0; k < NLANES; k++) compare("pending_at_end", k, 32'(expQ[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
